// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: opcodes, fetch FSM encoding,
// reset vector and the branch offset helper.
package mips_pkg;

    // Main decoder opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_J       = 6'b000010;
    // Presented while nothing is held; decodes to all-zero controls
    localparam logic [5:0] OP_INVALID = 6'b111111;

    // Fetch FSM state encoding
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Default first fetch address (word-aligned)
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Sign-extend a branch immediate and scale it to a byte offset
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus between the fetch unit, instruction memory and the decoder.
//
// Handshakes:
//   imem: request/grant. imem_req and imem_addr hold stable until a cycle
//         with imem_req=1 and imem_gnt=1; that cycle is the transfer. The
//         response (imem_rvalid/imem_rdata) is taken no earlier than the
//         following cycle and only while the fetch is waiting for it.
//   decode: valid/ready. instr, instr_pc and opcode stay stable while
//         instr_valid=1; the instruction is consumed in a cycle with
//         instr_valid=1 and instr_ready=1. jump/pcsr are sampled in that
//         same cycle and ignored otherwise.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  opcode;
    logic        jump;
    logic        pcsr;
    logic [31:0] retired;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid, opcode, retired,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, jump, pcsr
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, opcode, retired,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, jump, pcsr
    );
endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection: jump beats taken branch beats sequential.
// Shared with the pipelined core, so it stays purely combinational.
module pc_next
    import mips_pkg::*;
(
    input  logic [31:0] instr_pc,
    input  logic [31:0] instr,
    input  logic        jump,
    input  logic        pcsr,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic        unused_opcode_bits;

    // All arithmetic wraps modulo 2^32
    assign pc4                = instr_pc + 32'd4;
    assign unused_opcode_bits = ^instr[31:26];

    // Priority select of the next fetch address
    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = {pc4[31:28], instr[25:0], 2'b00};
        end else if (pcsr) begin
            next_pc = pc4 + branch_offset(instr[15:0]);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, runs one fetch at a time over the
// imem request/grant/response bus and presents the word to decode.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_if.master        bus,
    output logic [1:0]           state_o
);

    logic [1:0]  state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic        req_q,      req_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] retired_q,  retired_d;
    logic [31:0] next_pc;

    pc_next u_pc_next (
        .instr_pc (instr_pc_q),
        .instr    (instr_q),
        .jump     (bus.jump),
        .pcsr     (bus.pcsr),
        .next_pc  (next_pc)
    );

    // FSM transitions and datapath updates; inputs outside their state are ignored
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        retired_d  = retired_q;
        case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ: begin
                if (bus.imem_gnt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.instr_ready) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_REQ;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        // Request is registered: it is high exactly while the FSM sits in REQ
        req_d = (state_d == ST_REQ);
    end

    // State registers; reset aborts any fetch in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            retired_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            retired_q  <= retired_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = (state_q == ST_HOLD);
    assign bus.opcode      = (state_q == ST_HOLD) ? instr_q[31:26] : OP_INVALID;
    assign bus.retired     = retired_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a program table walked through the fetch
// unit plus hand-written sequences for backpressure, reset and jump priority.
module tb_instr_fetch;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_lo, state_hi;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    instr_fetch_if bus();
    instr_fetch_if bus_hi();

    instr_fetch u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_lo)
    );

    instr_fetch #(.RESET_PC(32'h4000_0000)) u_dut_hi (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_hi),
        .state_o (state_hi)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- instruction memory model ----------------
    logic [31:0] mem [logic [31:0]];
    bit          stale_mode = 1'b0;
    logic        pend_lo, pend_hi;
    logic [31:0] paddr_lo, paddr_hi;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Response one cycle after each grant; stale_mode forces a bogus response
    initial begin
        pend_lo = 1'b0; pend_hi = 1'b0;
        paddr_lo = 32'h0; paddr_hi = 32'h0;
        bus.imem_rvalid = 1'b0;    bus.imem_rdata = 32'h0;
        bus_hi.imem_rvalid = 1'b0; bus_hi.imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus.imem_rvalid    = pend_lo || stale_mode;
            bus.imem_rdata     = stale_mode ? 32'hDEAD_BEEF : mem_rd(paddr_lo);
            bus_hi.imem_rvalid = pend_hi;
            bus_hi.imem_rdata  = mem_rd(paddr_hi);
            pend_lo  = bus.imem_req && bus.imem_gnt && !rst;
            paddr_lo = bus.imem_addr;
            pend_hi  = bus_hi.imem_req && bus_hi.imem_gnt && !rst;
            paddr_hi = bus_hi.imem_addr;
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit probe(input bit hi, input bit want_valid);
        if (hi) return want_valid ? bus_hi.instr_valid : bus_hi.imem_req;
        return want_valid ? bus.instr_valid : bus.imem_req;
    endfunction

    task automatic wait_for(input bit hi, input bit want_valid, input string name);
        int n = 0;
        while (!probe(hi, want_valid) && n < 20) begin
            tick();
            n++;
        end
        if (!probe(hi, want_valid)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no event within %0d cycles", name, n);
        end
    endtask

    // ---------------- program table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic        jmp;
        logic        br;
        logic [5:0]  op;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];
    int   cons_cycle [NV];

    initial begin
        // each record's next fetch address is the following record's addr
        vecs[0] = '{32'h0000_0000, 32'h8C01_0004, 1'b0, 1'b0, OP_LW};
        vecs[1] = '{32'h0000_0004, 32'h0000_0020, 1'b0, 1'b0, OP_RTYPE};
        vecs[2] = '{32'h0000_0008, 32'h2001_0001, 1'b0, 1'b0, OP_ADDI};
        vecs[3] = '{32'h0000_000C, 32'hAC01_0000, 1'b0, 1'b0, OP_SW};
        vecs[4] = '{32'h0000_0010, 32'h1000_FFFE, 1'b0, 1'b1, OP_BEQ};  // 0x14-8  = 0x0C
        vecs[5] = '{32'h0000_000C, 32'hAC01_0000, 1'b0, 1'b0, OP_SW};
        vecs[6] = '{32'h0000_0010, 32'h1000_FFFE, 1'b0, 1'b0, OP_BEQ};  // not taken: 0x14
        vecs[7] = '{32'h0000_0014, 32'h1000_FFF9, 1'b0, 1'b1, OP_BEQ};  // 0x18-0x1C wraps
        vecs[8] = '{32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b0, OP_RTYPE}; // +4 wraps to 0
        for (int i = 0; i < NV; i++) mem[vecs[i].addr] = vecs[i].word;
        mem[32'h4000_0000] = 32'h0800_0010;  // J 0x10 in the 0x4 region

        bus.imem_gnt = 1'b1;    bus.instr_ready = 1'b0;    bus.jump = 1'b0;    bus.pcsr = 1'b0;
        bus_hi.imem_gnt = 1'b1; bus_hi.instr_ready = 1'b0; bus_hi.jump = 1'b0; bus_hi.pcsr = 1'b0;

        // ---- reset values ----
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",    {30'b0, state_lo}, {30'b0, ST_BOOT});
        check("rst_req",      {31'b0, bus.imem_req}, 32'h0);
        check("rst_addr",     bus.imem_addr, 32'h0);
        check("rst_instr",    bus.instr, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check("rst_valid",    {31'b0, bus.instr_valid}, 32'h0);
        check("rst_opcode",   {26'b0, bus.opcode}, {26'b0, OP_INVALID});
        check("rst_retired",  bus.retired, 32'h0);
        check("rst_hi_addr",  bus_hi.imem_addr, 32'h4000_0000);

        // ---- first fetch timing: cycle 1 BOOT, 2 REQ, 3 WAIT, 4 HOLD ----
        rst = 1'b0;
        cycle = 1;
        check("c1_no_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        check("c2_req",    {31'b0, bus.imem_req}, 32'h1);
        check("c2_addr",   bus.imem_addr, 32'h0);
        tick();
        check("c3_state",  {30'b0, state_lo}, {30'b0, ST_WAIT});
        check("c3_opcode", {26'b0, bus.opcode}, {26'b0, OP_INVALID});
        tick();
        check("c4_valid",  {31'b0, bus.instr_valid}, 32'h1);
        check("c4_opcode", {26'b0, bus.opcode}, {26'b0, OP_LW});

        // ---- program walk ----
        for (int i = 0; i < NV; i++) begin
            if (i > 0) begin
                wait_for(1'b0, 1'b0, $sformatf("vec%0d_req", i));
                check($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].addr);
            end
            wait_for(1'b0, 1'b1, $sformatf("vec%0d_valid", i));
            check($sformatf("vec%0d_instr_pc", i), bus.instr_pc, vecs[i].addr);
            check($sformatf("vec%0d_instr", i), bus.instr, vecs[i].word);
            check($sformatf("vec%0d_opcode", i), {26'b0, bus.opcode}, {26'b0, vecs[i].op});
            bus.jump = vecs[i].jmp;
            bus.pcsr = vecs[i].br;
            bus.instr_ready = 1'b1;
            tick();
            cons_cycle[i] = cycle;
            bus.instr_ready = 1'b0;
            bus.jump = 1'b0;
            bus.pcsr = 1'b0;
            if (i > 0) check($sformatf("vec%0d_spacing", i), cons_cycle[i] - cons_cycle[i-1], 32'd3);
            if (i == 3) check("retired_after_4", bus.retired, 32'd4);
        end

        // ---- wrap target and backpressure ----
        wait_for(1'b0, 1'b0, "wrap_req");
        check("wrap_addr", bus.imem_addr, 32'h0);
        wait_for(1'b0, 1'b1, "bp_valid");
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp%0d_valid", k), {31'b0, bus.instr_valid}, 32'h1);
            check($sformatf("bp%0d_instr", k), bus.instr, 32'h8C01_0004);
            check($sformatf("bp%0d_opcode", k), {26'b0, bus.opcode}, {26'b0, OP_LW});
            check($sformatf("bp%0d_no_req", k), {31'b0, bus.imem_req}, 32'h0);
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("retired_after_bp", bus.retired, NV + 1);

        // ---- reset while waiting for a response, then stale rvalid ----
        wait_for(1'b0, 1'b0, "pre_rst_req");
        check("pre_rst_addr", bus.imem_addr, 32'h4);
        tick();
        check("pre_rst_state", {30'b0, state_lo}, {30'b0, ST_WAIT});
        rst = 1'b1;
        #1;
        check("arst_state",   {30'b0, state_lo}, {30'b0, ST_BOOT});
        check("arst_retired", bus.retired, 32'h0);
        check("arst_opcode",  {26'b0, bus.opcode}, {26'b0, OP_INVALID});
        bus.imem_gnt = 1'b0;
        stale_mode = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        check("stale_boot_req",  {31'b0, bus.imem_req}, 32'h1);
        check("stale_boot_addr", bus.imem_addr, 32'h0);
        tick();
        tick();
        check("stale_state",  {30'b0, state_lo}, {30'b0, ST_REQ});
        check("stale_valid",  {31'b0, bus.instr_valid}, 32'h0);
        check("stale_opcode", {26'b0, bus.opcode}, {26'b0, OP_INVALID});
        stale_mode = 1'b0;
        bus.imem_gnt = 1'b1;
        wait_for(1'b0, 1'b1, "post_rst_valid");
        check("post_rst_instr",    bus.instr, 32'h8C01_0004);
        check("post_rst_instr_pc", bus.instr_pc, 32'h0);
        check("post_rst_retired",  bus.retired, 32'h0);

        // ---- jump beats branch, in the 0x4000_0000 region ----
        wait_for(1'b1, 1'b1, "hi_valid");
        check("hi_instr_pc", bus_hi.instr_pc, 32'h4000_0000);
        check("hi_opcode",   {26'b0, bus_hi.opcode}, {26'b0, OP_J});
        bus_hi.jump = 1'b1;
        bus_hi.pcsr = 1'b1;
        bus_hi.instr_ready = 1'b1;
        tick();
        bus_hi.instr_ready = 1'b0;
        bus_hi.jump = 1'b0;
        bus_hi.pcsr = 1'b0;
        wait_for(1'b1, 1'b0, "hi_req");
        check("hi_jump_addr", bus_hi.imem_addr, 32'h4000_0040);
        check("hi_retired",   bus_hi.retired, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the single-cycle MIPS core. It holds the PC, fetches one instruction at a time from instruction memory over a request/grant/response handshake, and presents it to decode. The instruction's opcode field drives the main decoder. The decoder's `jump` and branch-taken (`pcsr`) results return here to select the next PC. There is one outstanding fetch, no speculation and no delay slot.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address. Must be word-aligned.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req` output 1: fetch request, registered.
- `imem_addr` output 32: fetch address, equal to the current PC.
- `imem_gnt` input 1: memory accepts the request while `imem_req`=1.
- `imem_rvalid` input 1: response data valid.
- `imem_rdata` input 32: instruction word.
- `instr` output 32: held instruction.
- `instr_pc` output 32: PC of the held instruction.
- `instr_valid` output 1: the held instruction is presented to decode.
- `instr_ready` input 1: decode consumes the instruction this cycle.
- `opcode` output 6: to the main decoder. Equals `instr[31:26]` when `instr_valid`=1, else `OP_INVALID` (6'b111111), which decodes to all-zero controls.
- `jump` input 1: from the decoder for the held instruction.
- `pcsr` input 1: branch taken (zero & Branch) for the held instruction.
- `retired` output 32: count of consumed instructions.

## Operation
- Reset is asynchronous and active-high. While `rst` is asserted, all outputs and state take these values:
  - FSM state = BOOT.
  - PC = `RESET_PC`.
  - `imem_req`=0.
  - `instr`=0, `instr_pc`=0, `instr_valid`=0.
  - `opcode`=6'b111111.
  - `retired`=0.
- FSM states and transitions:
  - BOOT: go to REQ next cycle unconditionally.
  - REQ: `imem_req`=1, `imem_addr`=PC. If `imem_gnt`=1, go to WAIT; otherwise stay in REQ, holding request and address stable.
  - WAIT: if `imem_rvalid`=1, load `instr`←`imem_rdata` and `instr_pc`←PC, then go to HOLD.
  - HOLD: `instr_valid`=1. If `instr_ready`=1:
    - PC←next_pc.
    - `retired`←`retired`+1.
    - go to REQ.
- next_pc is computed from pc4 = `instr_pc`+4:
  - If `jump`=1: {pc4[31:28], `instr[25:0]`, 2'b00}.
  - Else if `pcsr`=1: pc4 + (sign-extended `instr[15:0]` << 2).
  - Else: pc4.
- If `jump` and `pcsr` are both 1, `jump` wins.
- All PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0, and branch targets wrap the same way. PC[1:0] stays 00 by construction.
- `jump` and `pcsr` are sampled only in HOLD with `instr_ready`=1; they are ignored otherwise.
- `imem_rvalid` outside WAIT, including a stale response arriving after reset, is ignored.
- `instr_ready` outside HOLD is ignored.
- `retired` wraps from 32'hFFFF_FFFF to 0.
- Reset asserted in any state aborts the fetch immediately. No request is issued in the first cycle after reset release (BOOT).

## Timing
- `imem_req` first rises 2 cycles after `rst` deasserts: one cycle in BOOT, then REQ.
- The earliest response is the cycle after grant; `imem_rvalid` in the grant cycle is ignored.
- `instr_valid` rises the cycle after `imem_rvalid` is accepted.
- Minimum spacing between consumed instructions is 3 cycles (REQ, WAIT, HOLD), reached with immediate gnt, rvalid one cycle later, and ready immediately.
- `opcode`, `instr` and `instr_pc` are stable for the whole HOLD period.
- The decoder path from `opcode` back to `jump`/`pcsr` is combinational within one cycle.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants: OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_ADDI 001000, OP_J 000010, OP_INVALID 111111;
  - the fetch FSM state encoding (BOOT, REQ, WAIT, HOLD);
  - the `RESET_PC` default.
- One combinational sub-module, `pc_next`, with inputs `instr_pc`, `instr`, `jump`, `pcsr` and output next_pc. It is shared later with the pipelined core.

## Test plan
- Reset release with `RESET_PC`=0, gnt held high, rvalid one cycle after gnt, data 32'h8C01_0004 → `imem_req` first high on cycle 2 with addr 0; `instr_valid` rises on cycle 4 with `opcode`=100011.
- Sequential fetch, ready always high and no jump/branch → addresses 0, 4, 8, 12 with exactly 3-cycle spacing; `retired`=4 after the fourth consume.
- BEQ at PC 32'h10, `instr[15:0]`=16'hFFFE, `pcsr`=1 → next addr 32'h0C. Same instruction with `pcsr`=0 → next addr 32'h14.
- J at PC 32'h4000_0000, `instr[25:0]`=26'h000_0010, `jump`=1 and `pcsr`=1 together → next addr 32'h4000_0040 (jump priority).
- Backpressure and wrap:
  - `instr_ready` low for 5 cycles in HOLD → `instr` and `opcode` held stable and no new `imem_req`;
  - PC 32'hFFFF_FFFC consumed sequentially → next addr 0.
- Reset while in WAIT, then a stale rvalid arrives → ignored; the next fetch is from `RESET_PC` and `opcode` reads 111111 until valid.
